// File: rtl/cs_pkg.sv
// Shared control-store constants: geometry, loader state encoding, error codes.
package cs_pkg;

    localparam int unsigned CS_ADDR_W = 6;
    localparam int unsigned CS_DATA_W = 23;
    localparam logic [7:0]  CS_HEADER = 8'hA5;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StCount,
        StB0,
        StB1,
        StB2,
        StCsum,
        StDone,
        StErr
    } cs_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_PAD   = 2'b10;
    localparam logic [1:0] ERR_CSUM  = 2'b11;

    // Bits of the third byte that lie above the word and must be zero.
    function automatic logic [7:0] pad_mask(input int unsigned data_w);
        logic [15:0] m;
        m = 16'h00FF << (data_w - 16);
        return m[7:0];
    endfunction

endpackage

// File: rtl/cs_loader_if.sv
// Byte-stream input and control-store write port of the loader.
interface cs_loader_if
    import cs_pkg::*;
#(
    parameter int unsigned ADDR_W = CS_ADDR_W,
    parameter int unsigned DATA_W = CS_DATA_W
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/cs_word_assembler.sv
// Collects B0/B1 and combines them with the live B2 byte into a microinstruction word.
module cs_word_assembler
    import cs_pkg::*;
#(
    parameter int unsigned DATA_W = CS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              pad_err
);
    localparam logic [7:0] PadMask = pad_mask(DATA_W);

    logic [15:0] low_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_q <= '0;
        end else if (shift_en) begin
            low_q <= {byte_in, low_q[15:8]};
        end
    end

    // Word is presented while B2 is on the bus, so the write can be registered on its handshake.
    assign word    = DATA_W'({byte_in, low_q});
    assign pad_err = |(byte_in & PadMask);
endmodule

// File: rtl/cs_loader.sv
// Framed byte-stream loader for the microcode control store with frame checking.
module cs_loader
    import cs_pkg::*;
#(
    parameter int unsigned ADDR_W = CS_ADDR_W,
    parameter int unsigned DATA_W = CS_DATA_W,
    parameter logic [7:0]  HEADER = CS_HEADER
) (
    input  logic              clk,
    input  logic              reset,
    cs_loader_if.slave        bus,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_written
);
    cs_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              accept, shift_en, pad_err;
    logic [DATA_W-1:0] word;

    cs_word_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .byte_in  (bus.in_data),
        .word     (word),
        .pad_err  (pad_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            words_q   <= '0;
            err_q     <= ERR_NONE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            csum_q    <= csum_d;
            words_q   <= words_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        words_d   = words_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        shift_en  = 1'b0;
        bus.in_ready = (state_q != StDone) && (state_q != StErr);
        accept    = bus.in_valid && bus.in_ready;

        unique case (state_q)
            StIdle: begin
                if (accept && bus.in_data == HEADER) begin
                    state_d = StAddr;
                    csum_d  = '0;
                    words_d = '0;
                end
            end
            StAddr: begin
                if (accept) begin
                    ptr_d   = bus.in_data[ADDR_W-1:0];
                    csum_d  = csum_q ^ bus.in_data;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.in_data;
                    if (bus.in_data == 8'h00) begin
                        state_d = StErr;
                        err_d   = ERR_COUNT;
                    end else begin
                        rem_d   = bus.in_data;
                        state_d = StB0;
                    end
                end
            end
            StB0, StB1: begin
                if (accept) begin
                    csum_d   = csum_q ^ bus.in_data;
                    shift_en = 1'b1;
                    state_d  = (state_q == StB0) ? StB1 : StB2;
                end
            end
            StB2: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.in_data;
                    if (pad_err) begin
                        state_d = StErr;
                        err_d   = ERR_PAD;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = word;
                        ptr_d     = ptr_q + 1'b1;
                        rem_d     = rem_q - 8'd1;
                        words_d   = words_q + 1'b1;
                        state_d   = (rem_q == 8'd1) ? StCsum : StB0;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (bus.in_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            StDone, StErr: begin
                if (clear) begin
                    state_d = StIdle;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
    assign done          = (state_q == StDone);
    assign error         = (state_q == StErr);
    assign err_code      = err_q;
    assign words_written = words_q;
endmodule

// File: tb/tb_cs_loader.sv
// Scoreboard bench for cs_loader: expected writes queued by stimulus, checked by a write monitor.
module tb_cs_loader;
    import cs_pkg::*;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic [6:0] words_written;
    int         cyc;
    int         tests;
    int         fails;

    typedef struct {
        logic [5:0]  a;
        logic [22:0] d;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    logic [22:0] fw[$];

    cs_loader_if bus ();

    cs_loader dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .clear         (clear),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .words_written (words_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int hs);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        hs = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic sb(input logic [7:0] b);
        int hs;
        send_byte(b, hs);
    endtask

    task automatic push_exp(input logic [5:0] a, input logic [22:0] d, input int c);
        exp_t e;
        e.a = a;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Sends a frame carrying the words in fw; stall idles the bus between B0 and B1.
    task automatic frame(input logic [5:0] addr, input bit good_csum, input int stall);
        logic [7:0] cs;
        logic [7:0] b0, b1, b2;
        logic [5:0] a;
        int         hs;
        cs = {2'b00, addr} ^ 8'(fw.size());
        a  = addr;
        sb(8'hA5);
        sb({2'b00, addr});
        sb(8'(fw.size()));
        foreach (fw[i]) begin
            b0 = fw[i][7:0];
            b1 = fw[i][15:8];
            b2 = {1'b0, fw[i][22:16]};
            cs = cs ^ b0 ^ b1 ^ b2;
            sb(b0);
            repeat (stall) @(posedge clk);
            #0;
            sb(b1);
            send_byte(b2, hs);
            push_exp(a, fw[i], hs);
            a = a + 6'd1;
        end
        sb(good_csum ? cs : ~cs);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic chk_status(input string name, input logic d, input logic e, input logic [1:0] ec,
                              input logic [6:0] ww);
        chk({name, "_done"}, {31'd0, done}, {31'd0, d});
        chk({name, "_error"}, {31'd0, error}, {31'd0, e});
        chk({name, "_err_code"}, {30'd0, err_code}, {30'd0, ec});
        chk({name, "_words"}, {25'd0, words_written}, {25'd0, ww});
    endtask

    initial begin
        int hs;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (bus.wr_en === 1'b1) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                                 bus.wr_addr, bus.wr_data);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (bus.wr_addr !== e.a || bus.wr_data !== e.d || cyc != e.c) begin
                            fails++;
                            $display("FAIL write: got addr %0h data %0h cyc %0d, expected addr %0h data %0h cyc %0d",
                                     bus.wr_addr, bus.wr_data, cyc, e.a, e.d, e.c);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {26'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {9'd0, bus.wr_data}, 32'd0);
        chk_status("rst", 1'b0, 1'b0, ERR_NONE, 7'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word, hand-computed bytes: csum 04^01^80^84^05 = 04.
        sb(8'hA5); sb(8'h04); sb(8'h01); sb(8'h80); sb(8'h84);
        chk("single_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h05, hs);
        push_exp(6'h04, 23'h058480, hs);
        sb(8'h04);
        chk_status("single", 1'b1, 1'b0, ERR_NONE, 7'd1);
        chk("single_in_ready", {31'd0, bus.in_ready}, 32'd0);
        pulse_clear();
        chk("single_cleared", {31'd0, done}, 32'd0);

        // Address wrap, csum 3F^02^01^00^00^FF^FF^7F = 43.
        sb(8'hA5); sb(8'h3F); sb(8'h02);
        sb(8'h01); sb(8'h00); send_byte(8'h00, hs); push_exp(6'h3F, 23'h000001, hs);
        sb(8'hFF); sb(8'hFF); send_byte(8'h7F, hs); push_exp(6'h00, 23'h7FFFFF, hs);
        sb(8'h43);
        chk_status("wrap", 1'b1, 1'b0, ERR_NONE, 7'd2);
        chk("wrap_hold_addr", {26'd0, bus.wr_addr}, 32'h0);
        chk("wrap_hold_data", {9'd0, bus.wr_data}, 32'h7FFFFF);
        pulse_clear();

        // Zero count.
        sb(8'hA5); sb(8'h10); sb(8'h00);
        chk_status("zero", 1'b0, 1'b1, ERR_COUNT, 7'd0);
        chk("zero_in_ready", {31'd0, bus.in_ready}, 32'd0);
        pulse_clear();
        chk("zero_clr_ready", {31'd0, bus.in_ready}, 32'd1);
        chk_status("zero_clr", 1'b0, 1'b0, ERR_NONE, 7'd0);

        // Pad violation on B2 bit 7.
        sb(8'hA5); sb(8'h00); sb(8'h01); sb(8'h00); sb(8'h00); sb(8'h80);
        chk_status("pad", 1'b0, 1'b1, ERR_PAD, 7'd0);
        pulse_clear();

        // Bad checksum: word still written.
        sb(8'hA5); sb(8'h04); sb(8'h01); sb(8'h80); sb(8'h84);
        send_byte(8'h05, hs);
        push_exp(6'h04, 23'h058480, hs);
        sb(8'hFF);
        chk_status("csum", 1'b0, 1'b1, ERR_CSUM, 7'd1);
        pulse_clear();

        // Garbage then a normal frame.
        sb(8'h00); sb(8'hFF); sb(8'h5A);
        chk("garbage_busy", {31'd0, busy}, 32'd0);
        fw = '{23'h058480};
        frame(6'h04, 1'b1, 0);
        chk_status("garbage", 1'b1, 1'b0, ERR_NONE, 7'd1);
        pulse_clear();

        // Stall between B0 and B1.
        frame(6'h04, 1'b1, 10);
        chk_status("stall", 1'b1, 1'b0, ERR_NONE, 7'd1);
        pulse_clear();

        // Reset in B1 of word 2 of a 3-word frame.
        sb(8'hA5); sb(8'h08); sb(8'h03);
        sb(8'h11); sb(8'h22); send_byte(8'h33, hs); push_exp(6'h08, 23'h332211, hs);
        sb(8'h44); sb(8'h55);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_words", {25'd0, words_written}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb(8'h66);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        fw = '{23'h012345, 23'h6789AB};
        frame(6'h20, 1'b1, 0);
        chk_status("post_rst", 1'b1, 1'b0, ERR_NONE, 7'd2);
        pulse_clear();

        repeat (4) @(posedge clk);
        #1;
        chk("pending_writes", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cs_loader.md
Name: cs_loader

Overview:
- Writer side of the 64 x 23 microcode control store. The rest of the pipeline only reads that store, indexed by a 6-bit address.
- Accepts a framed byte stream over a valid/ready handshake. Assembles 23-bit microinstructions and issues one write per word to a writable control store.
- Checks the frame (zero count, pad bits, XOR checksum) and reports done or error.
- Sits between the debug/boot byte source and the control store write port.

Parameters:
- ADDR_W, 6, control store address width (64 entries).
- DATA_W, 23, microinstruction width. Must be in 17..24, so three bytes per word.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte source has a byte.
- in_data  in  8  byte.
- in_ready  out  1  loader accepts a byte. A byte transfers when in_valid && in_ready.
- clear  in  1  single-cycle pulse. Returns the loader from DONE or ERR to IDLE.
- wr_en  out  1  control store write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- busy  out  1  a frame is in progress (states ADDR..CSUM).
- done  out  1  frame accepted; held until clear.
- error  out  1  frame rejected; held until clear.
- err_code  out  2  00 none, 01 count zero, 10 nonzero pad bits, 11 checksum mismatch.
- words_written  out  ADDR_W+1  words written in the current or last frame.

Behaviour:
- Reset (async, active-high): state=IDLE. wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, err_code=00, words_written=0.
- Frame format: HEADER, ADDR, COUNT, then COUNT x {B0, B1, B2}, then CSUM.
  - Words are little-endian: word = {B2, B1, B0}[DATA_W-1:0].
  - CSUM = XOR of ADDR, COUNT and all data bytes. HEADER is excluded.
- in_ready=1 in IDLE, ADDR, COUNT, B0, B1, B2, CSUM. in_ready=0 in DONE and ERR.
- States. Each transition below happens on an accepted byte unless stated otherwise.
  - IDLE: byte==HEADER -> ADDR, and clear the checksum accumulator and words_written. Any other byte is discarded; stay in IDLE.
  - ADDR: latch ptr=byte[ADDR_W-1:0]. Upper bits are ignored but still included in the checksum. -> COUNT.
  - COUNT: byte==0 -> ERR, err_code=01. Otherwise latch remaining=byte -> B0.
    - Counts above 64 are legal; the address wraps.
  - B0 -> B1 -> B2.
    - On B2, any nonzero bit above DATA_W-17 -> ERR, err_code=10, and no write.
    - Otherwise register the write: the next cycle has wr_en=1, wr_addr=ptr, wr_data=word.
    - Then ptr=ptr+1 mod 2^ADDR_W (0x3F wraps to 0x00), remaining-=1, words_written+=1.
    - Next state is B0 if remaining!=0, else CSUM.
  - CSUM: byte==accumulator -> DONE. Otherwise -> ERR, err_code=11.
    - Words already written stay written; there is no rollback.
    - done or error rises the cycle after the CSUM byte is accepted.
  - DONE / ERR: hold the flag. clear -> IDLE, deasserting done, error and err_code. clear in any other state is ignored.
- Latency: wr_en pulses exactly one cycle after the B2 handshake cycle.
  - The loader keeps accepting bytes during that cycle.
  - Back-to-back streaming at one byte per cycle is supported, so the minimum spacing between writes is 3 cycles.
- wr_addr and wr_data hold their last values while wr_en=0.
- Reset mid-frame: abort immediately to IDLE with no partial write. A write already registered is dropped if reset lands in its strobe cycle.
- in_valid held low mid-frame: wait indefinitely; there is no timeout.

Decomposition:
- Shared package cs_pkg holds:
  - CS_ADDR_W=6 and CS_DATA_W=23, shared with the control store.
  - The state encoding constants.
  - The err_code constants.
  - The HEADER default.
- One natural sub-module, cs_word_assembler: shifts in 3 bytes, flags pad-bit violations, and presents the word. The FSM, checksum and pointer stay in cs_loader.

Test Plan:
- Single word: A5,04,01,80,84,05,04 -> one wr_en with wr_addr=0x04, wr_data=23'h058480, one cycle after byte 05. Then done=1, err_code=00, words_written=1.
- Wrap: A5,3F,02, then words 23'h000001 and 23'h7FFFFF, correct CSUM -> writes to 0x3F then 0x00, done=1, words_written=2.
- Zero count: A5,10,00 -> ERR with err_code=01, no wr_en, in_ready=0. Then clear -> IDLE with in_ready=1.
- Pad violation: A5,00,01,00,00,80 -> error=1, err_code=10, no wr_en. Bad checksum on a valid 1-word frame -> the word is written, then error=1, err_code=11.
- Garbage before header: bytes 00,FF,5A then a valid frame -> garbage ignored, frame loads normally. Stall in_valid for 10 cycles between B0 and B1 -> same result.
- Reset asserted while in B1 of word 2 of a 3-word frame -> immediately IDLE, busy=0, words_written=0 with no further writes. A subsequent frame loads normally.
